// File: rtl/skinny_pkg.sv
// Shared types and helpers for the SKINNY-128-384+ round controller.
package skinny_pkg;

  localparam int unsigned SKINNY_ROUNDS = 40;
  localparam int unsigned RC_W          = 6;
  localparam int unsigned RCNT_W        = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ctrl_state_t;

  // One step of the 6-bit round-constant LFSR.
  function automatic logic [RC_W-1:0] lfsr_step(input logic [RC_W-1:0] rc);
    return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

  // TK1 counter path width: 64 bits, or 128 when the full counter is used.
  function automatic int unsigned cnt_width(input int unsigned fullcnt);
    return 64 + 64 * fullcnt;
  endfunction

endpackage

// File: rtl/skinny_rc_gen.sv
// Combinational round-constant generator: produces the NUMRND constants for
// the current cycle and the LFSR value after NUMRND steps.
module skinny_rc_gen
  import skinny_pkg::*;
#(
  parameter int unsigned NUMRND = 2
) (
  input  logic [RC_W-1:0]        rc,
  output logic [6*NUMRND-1:0]    rnd_const,
  output logic [RC_W-1:0]        rc_next
);

  logic [RC_W-1:0] chain [NUMRND+1];

  assign chain[0] = rc;

  // Slice i carries the LFSR advanced i+1 steps from the registered value.
  for (genvar i = 0; i < NUMRND; i++) begin : g_step
    assign chain[i+1]          = lfsr_step(chain[i]);
    assign rnd_const[6*i +: 6] = chain[i+1];
  end

  assign rc_next = chain[NUMRND];

endmodule

// File: rtl/skinny_round_ctrl.sv
// Iterative controller and register stage around the SKINNY-128-384+ round
// datapath. Optional macro SKINNY_ROUND_ABORT_EN adds an abort input that
// returns RUN/DONE to IDLE without touching the data registers.
module skinny_round_ctrl
  import skinny_pkg::*;
#(
  parameter  int unsigned NUMRND  = 2,
  parameter  int unsigned FULLCNT = 1,
  localparam int unsigned CW      = cnt_width(FULLCNT),
  localparam int unsigned KW      = 6 * NUMRND
) (
  input  logic           clk,
  input  logic           rst,
`ifdef SKINNY_ROUND_ABORT_EN
  input  logic           abort,
`endif
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [127:0]   in_state,
  input  logic [127:0]   in_key,
  input  logic [127:0]   in_tweak,
  input  logic [CW-1:0]  in_cnt,
  output logic [127:0]   rnd_state,
  output logic [127:0]   rnd_key,
  output logic [127:0]   rnd_tweak,
  output logic [CW-1:0]  rnd_cnt,
  output logic [KW-1:0]  rnd_const,
  input  logic [127:0]   nxt_state,
  input  logic [127:0]   nxt_key,
  input  logic [127:0]   nxt_tweak,
  input  logic [CW-1:0]  nxt_cnt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [127:0]   out_state
);

  // Rounds-per-cycle must divide the round count in one of the supported ways.
  if (NUMRND != 1 && NUMRND != 2 && NUMRND != 4 && NUMRND != 5 && NUMRND != 8) begin : g_bad_numrnd
    $error("skinny_round_ctrl: NUMRND must be 1, 2, 4, 5 or 8");
  end
  if (FULLCNT > 1) begin : g_bad_fullcnt
    $error("skinny_round_ctrl: FULLCNT must be 0 or 1");
  end

  logic abort_w;
`ifdef SKINNY_ROUND_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  ctrl_state_t       state_q, state_d;
  logic [127:0]      st_q, st_d;
  logic [127:0]      key_q, key_d;
  logic [127:0]      tw_q, tw_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RC_W-1:0]   rc_q, rc_d, rc_adv;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              in_ready_d, out_valid_d;

  skinny_rc_gen #(.NUMRND(NUMRND)) u_rc_gen (
    .rc        (rc_q),
    .rnd_const (rnd_const),
    .rc_next   (rc_adv)
  );

  assign rnd_state = st_q;
  assign rnd_key   = key_q;
  assign rnd_tweak = tw_q;
  assign rnd_cnt   = cnt_q;
  assign out_state = st_q;

  // State, data and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      st_q      <= '0;
      key_q     <= '0;
      tw_q      <= '0;
      cnt_q     <= '0;
      rc_q      <= '0;
      rcnt_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      st_q      <= st_d;
      key_q     <= key_d;
      tw_q      <= tw_d;
      cnt_q     <= cnt_d;
      rc_q      <= rc_d;
      rcnt_q    <= rcnt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
    end
  end

  // Next-state, register updates and handshake flags.
  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    tw_d    = tw_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      IDLE: begin
        if (!abort_w && in_valid) begin
          st_d    = in_state;
          key_d   = in_key;
          tw_d    = in_tweak;
          cnt_d   = in_cnt;
          rc_d    = '0;
          rcnt_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort_w) begin
          state_d = IDLE;
        end else begin
          st_d   = nxt_state;
          key_d  = nxt_key;
          tw_d   = nxt_tweak;
          cnt_d  = nxt_cnt;
          rc_d   = rc_adv;
          rcnt_d = rcnt_q + RCNT_W'(NUMRND);
          if (rcnt_d == RCNT_W'(SKINNY_ROUNDS)) state_d = DONE;
        end
      end
      DONE: begin
        if (abort_w || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Directed bench for skinny_round_ctrl (NUMRND=2, FULLCNT=1). A simple
// stand-in round function plays the datapath; expected results come from an
// independent 40-round reference loop with its own constant sequence.
module tb_skinny_round_ctrl;

  localparam int unsigned NR = 2;
  localparam int unsigned CW = 128;
  localparam int unsigned KW = 6 * NR;

  typedef struct packed {
    logic [127:0] s;
    logic [127:0] k;
    logic [127:0] t;
    logic [127:0] c;
  } blk_t;

  logic          clk = 1'b0;
  logic          rst;
`ifdef SKINNY_ROUND_ABORT_EN
  logic          abort;
`endif
  logic          in_valid, in_ready;
  logic [127:0]  in_state, in_key, in_tweak;
  logic [CW-1:0] in_cnt;
  logic [127:0]  rnd_state, rnd_key, rnd_tweak;
  logic [CW-1:0] rnd_cnt;
  logic [KW-1:0] rnd_const;
  logic [127:0]  nxt_state, nxt_key, nxt_tweak;
  logic [CW-1:0] nxt_cnt;
  logic          out_valid, out_ready;
  logic [127:0]  out_state;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  skinny_round_ctrl #(.NUMRND(NR), .FULLCNT(1)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SKINNY_ROUND_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_tweak  (in_tweak),
    .in_cnt    (in_cnt),
    .rnd_state (rnd_state),
    .rnd_key   (rnd_key),
    .rnd_tweak (rnd_tweak),
    .rnd_cnt   (rnd_cnt),
    .rnd_const (rnd_const),
    .nxt_state (nxt_state),
    .nxt_key   (nxt_key),
    .nxt_tweak (nxt_tweak),
    .nxt_cnt   (nxt_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  // Stand-in single round: rotations, key/tweak mixing and the round constant.
  function automatic blk_t toy_round(input blk_t b, input logic [5:0] rc);
    blk_t r;
    r.s = {b.s[122:0], b.s[127:123]} ^ b.k ^ b.t ^ b.c ^ {122'd0, rc};
    r.k = {b.k[119:0], b.k[127:120]} + 128'd1;
    r.t = {b.t[111:0], b.t[127:112]};
    r.c = b.c + 128'd3;
    return r;
  endfunction

  // Reference: nr sequential rounds with the constants 01, 03, 07, ...
  function automatic blk_t golden(input blk_t b, input int nr);
    blk_t       r = b;
    logic [5:0] c = 6'h00;
    for (int i = 0; i < nr; i++) begin
      c = {c[4:0], ~(c[5] ^ c[4])};
      r = toy_round(r, c);
    end
    return r;
  endfunction

  // Datapath model: NR rounds per cycle using the DUT's constant slices.
  always_comb begin
    blk_t dp;
    dp = {rnd_state, rnd_key, rnd_tweak, rnd_cnt};
    for (int i = 0; i < NR; i++) dp = toy_round(dp, rnd_const[6*i +: 6]);
    nxt_state = dp.s;
    nxt_key   = dp.k;
    nxt_tweak = dp.t;
    nxt_cnt   = dp.c;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input blk_t b);
    in_state = b.s;
    in_key   = b.k;
    in_tweak = b.t;
    in_cnt   = b.c;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
  endtask

  // Safety net in case a bounded wait is bypassed by a broken design.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    blk_t blk_a, blk_b, blk_c, blk_d;
    int   n;
    logic seen;

    blk_a = {128'h0, 128'h000102030405060708090a0b0c0d0e0f,
             128'h101112131415161718191a1b1c1d1e1f, 128'h1};
    blk_b = {128'hdeadbeef_01234567_89abcdef_cafef00d, 128'h55aa,
             128'hffffffff_00000000_ffffffff_00000000, 128'h2};
    blk_c = {128'h1, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
             128'h0f0f, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe};
    blk_d = {128'h77, 128'h66, 128'h55, 128'h44};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
`ifdef SKINNY_ROUND_ABORT_EN
    abort = 1'b0;
`endif
    drive('0);
    tick(); tick();
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_const", 128'(rnd_const), 128'h0C1);
    check("rst_state", rnd_state, 128'd0);

    // Idle with in_valid low: nothing moves.
    drive(blk_a);
    repeat (5) tick();
    check("idle_in_ready", 128'(in_ready), 128'd1);
    check("idle_state", rnd_state, 128'd0);
    check("idle_key", rnd_key, 128'd0);

    // Single block, constants of the first two RUN cycles, latency, result.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("a_in_ready", 128'(in_ready), 128'd0);
    check("a_load", rnd_key, blk_a.k);
    check("a_const0", 128'(rnd_const), 128'h0C1);
    tick();
    check("a_const1", 128'(rnd_const), 128'h3C7);
    wait_done(60, n);
    check("a_latency", 128'(n + 1), 128'd20);
    check("a_result", out_state, golden(blk_a, 40).s);

    // Backpressure in DONE.
    for (int i = 0; i < 7; i++) begin
      tick();
      check("bp_valid", 128'(out_valid), 128'd1);
      check("bp_state", out_state, golden(blk_a, 40).s);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", 128'(in_ready), 128'd1);
    check("bp_release_valid", 128'(out_valid), 128'd0);

    // Back-to-back blocks with in_valid and out_ready held high.
    drive(blk_b);
    in_valid = 1'b1;
    tick();
    drive(blk_c);
    check("b_load", rnd_state, blk_b.s);
    check("b_const0", 128'(rnd_const), 128'h0C1);
    wait_done(60, n);
    check("b_latency", 128'(n), 128'd20);
    check("b_result", out_state, golden(blk_b, 40).s);
    tick();
    check("b2b_idle_ready", 128'(in_ready), 128'd1);
    check("b2b_idle_valid", 128'(out_valid), 128'd0);
    tick();
    check("c_accept", 128'(in_ready), 128'd0);
    check("c_load", rnd_state, blk_c.s);
    check("c_const0", 128'(rnd_const), 128'h0C1);
    wait_done(60, n);
    check("c_latency", 128'(n), 128'd20);
    check("c_result", out_state, golden(blk_c, 40).s);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("c_drain_ready", 128'(in_ready), 128'd1);

    // Reset in the middle of RUN.
    drive(blk_d);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    check("d_mid_state", rnd_state, golden(blk_d, 18).s);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_in_ready", 128'(in_ready), 128'd1);
    check("mrst_valid", 128'(out_valid), 128'd0);
    check("mrst_state", rnd_state, 128'd0);
    check("mrst_tweak", rnd_tweak, 128'd0);
    check("mrst_cnt", rnd_cnt, 128'd0);
    check("mrst_const", 128'(rnd_const), 128'h0C1);
    seen = 1'b0;
    repeat (25) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("mrst_never_valid", 128'(seen), 128'd0);

`ifdef SKINNY_ROUND_ABORT_EN
    // Abort in IDLE beats in_valid; abort in RUN returns to IDLE, data held.
    drive(blk_b);
    in_valid = 1'b1;
    abort    = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_idle_no_accept", 128'(in_ready), 128'd1);
    check("ab_idle_no_load", rnd_state, 128'd0);
    tick();
    in_valid = 1'b0;
    check("ab_accept", 128'(in_ready), 128'd0);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ab_run_idle", 128'(in_ready), 128'd1);
    check("ab_run_valid", 128'(out_valid), 128'd0);
    check("ab_run_hold", rnd_state, golden(blk_b, 4).s);
    drive(blk_c);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(60, n);
    check("ab_next_latency", 128'(n), 128'd20);
    check("ab_next_result", out_state, golden(blk_c, 40).s);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
